// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   Receive-side byte buffer behind a UART receiver. A byte is captured on
//   each rx_end pulse and held in a first-word-fall-through FIFO until the bus
//   side pops it. Fill level, a sticky overrun flag and a threshold interrupt
//   are reported so that software can service the UART in bursts.
//
// Ports
//   clk      in   clock; all state updates on the rising edge
//   reset    in   asynchronous active-low reset
//   rx_end   in   one-cycle push strobe; rx_data is valid
//   rx_data  in   received byte
//   rd_en    in   pop request (ignored while empty)
//   flush    in   synchronous discard of all entries
//   ovr_clr  in   synchronous clear of the overrun flag
//   rd_data  out  head entry, 8'h00 while empty
//   empty    out  no entries held
//   full     out  level == DEPTH
//   level    out  entries held, 0..DEPTH
//   overrun  out  sticky: a byte was dropped because the FIFO was full
//   irq      out  (level >= THRESH) | overrun
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int THRESH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_end,
  input  logic [7:0]        rx_data,
  input  logic              rd_en,
  input  logic              flush,
  input  logic              ovr_clr,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              overrun,
  output logic              irq
);

  localparam logic [ADDR_W:0]   DEPTH_L  = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   THRESH_L = THRESH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wp_q, wp_d;
  logic [ADDR_W-1:0] rp_q, rp_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ovr_q, ovr_d;

  logic              pop_ok_s;
  logic              push_ok_s;
  logic              drop_s;

  // Status decode straight from the registers.
  assign empty   = (cnt_q == {(ADDR_W+1){1'b0}});
  assign full    = (cnt_q == DEPTH_L);
  assign level   = cnt_q;
  assign rd_data = empty ? 8'h00 : mem_q[rp_q];
  assign overrun = ovr_q;
  assign irq     = (cnt_q >= THRESH_L) | ovr_q;

  // A pop while full frees the slot the simultaneous push lands in.
  // Flush discards any arriving byte and never counts as an overrun.
  assign pop_ok_s  = rd_en & ~empty;
  assign push_ok_s = rx_end & (~full | pop_ok_s) & ~flush;
  assign drop_s    = rx_end & full & ~pop_ok_s & ~flush;

  // Next-state for pointers, count and the sticky overrun flag.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d  = {ADDR_W{1'b0}};
      rp_d  = {ADDR_W{1'b0}};
      cnt_d = {(ADDR_W+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wp_d = wp_q + PTR_ONE;
      end else begin
        wp_d = wp_q;
      end
      if (pop_ok_s) begin
        rp_d = rp_q + PTR_ONE;
      end else begin
        rp_d = rp_q;
      end
      if (push_ok_s && !pop_ok_s) begin
        cnt_d = cnt_q + CNT_ONE;
      end else if (pop_ok_s && !push_ok_s) begin
        cnt_d = cnt_q - CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end
    // Setting wins over a simultaneous clear.
    if (drop_s) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q  <= {ADDR_W{1'b0}};
      rp_q  <= {ADDR_W{1'b0}};
      cnt_q <= {(ADDR_W+1){1'b0}};
      ovr_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
    end
  end

  // Storage array; contents are qualified by cnt, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wp_q] <= rx_data;
    end
  end

endmodule
